// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: widths, branch funct3 encodings, EX/MEM FSM states,
// ALU control codes and the registered EX/MEM payload.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } exmem_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_e;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  rs2_data;
    logic [REG_W-1:0] rd;
    logic [F3_W-1:0]  funct3;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } mem_payload_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM pipeline bus: upstream beat + handshake, downstream register and redirect.
interface ex_mem_stage_if;
  import riscv_pkg::*;

  logic             ex_valid;
  logic             ex_ready;
  logic [XLEN-1:0]  alu_result;
  logic             z_flag;
  logic             n_flag;
  logic             c_flag;
  logic             o_flag;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [F3_W-1:0]  ex_funct3;
  logic             ex_is_branch;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             flush;
  logic             mem_ready;
  logic             mem_valid;
  logic [XLEN-1:0]  mem_result;
  logic [XLEN-1:0]  mem_rs2_data;
  logic [REG_W-1:0] mem_rd;
  logic [F3_W-1:0]  mem_funct3;
  logic             mem_reg_write;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;

  modport master (
    output ex_valid, alu_result, z_flag, n_flag, c_flag, o_flag, ex_pc, ex_imm,
           ex_rs2_data, ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, flush, mem_ready,
    input  ex_ready, mem_valid, mem_result, mem_rs2_data, mem_rd, mem_funct3,
           mem_reg_write, mem_mem_read, mem_mem_write, redirect_valid, redirect_pc
  );

  modport slave (
    input  ex_valid, alu_result, z_flag, n_flag, c_flag, o_flag, ex_pc, ex_imm,
           ex_rs2_data, ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, flush, mem_ready,
    output ex_ready, mem_valid, mem_result, mem_rs2_data, mem_rd, mem_funct3,
           mem_reg_write, mem_mem_read, mem_mem_write, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluation from ALU flags (C=1 means no borrow).
module branch_cond
  import riscv_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic            z_flag,
  input  logic            n_flag,
  input  logic            c_flag,
  input  logic            o_flag,
  output logic            cond_c
);

  // Decode funct3 to a taken condition; reserved encodings never take
  always_comb begin
    cond_c = 1'b0;
    case (funct3)
      F3_BEQ:  cond_c = z_flag;
      F3_BNE:  cond_c = !z_flag;
      F3_BLT:  cond_c = n_flag ^ o_flag;
      F3_BGE:  cond_c = !(n_flag ^ o_flag);
      F3_BLTU: cond_c = !c_flag;
      F3_BGEU: cond_c = c_flag;
      default: cond_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and one-cycle redirect.
// Optional feature: define EXMEM_BRANCH_STATS_EN to add branch_count/taken_count.
module ex_mem_stage
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  ex_mem_stage_if.slave  bus
`ifdef EXMEM_BRANCH_STATS_EN
  ,
  output logic [XLEN-1:0] branch_count,
  output logic [XLEN-1:0] taken_count
`endif
);

  exmem_state_e    state;
  exmem_state_e    state_next;
  logic            cond_c;
  logic            taken_c;
  logic            capture_c;
  logic            redirect_next;
  logic            mem_valid_next;
  logic [XLEN-1:0] target_c;
  mem_payload_t    pay_c;
  mem_payload_t    pay_q;
  logic            mem_valid_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  branch_cond u_branch_cond (
    .funct3 (bus.ex_funct3),
    .z_flag (bus.z_flag),
    .n_flag (bus.n_flag),
    .c_flag (bus.c_flag),
    .o_flag (bus.o_flag),
    .cond_c (cond_c)
  );

  assign taken_c  = bus.ex_is_jal | bus.ex_is_jalr | (bus.ex_is_branch & cond_c);
  assign target_c = bus.ex_is_jalr ? (bus.alu_result & XLEN'(32'hFFFF_FFFE))
                                   : XLEN'(bus.ex_pc + bus.ex_imm);

  // The shadow cycle swallows the wrong-path beat, so upstream is never stalled then
  assign bus.ex_ready = (state == ST_SHADOW) | !mem_valid_q | bus.mem_ready;

  assign pay_c.result    = (bus.ex_is_jal | bus.ex_is_jalr) ? XLEN'(bus.ex_pc + XLEN'(4))
                                                            : bus.alu_result;
  assign pay_c.rs2_data  = bus.ex_rs2_data;
  assign pay_c.rd        = bus.ex_rd;
  assign pay_c.funct3    = bus.ex_funct3;
  assign pay_c.reg_write = bus.ex_reg_write;
  assign pay_c.mem_read  = bus.ex_mem_read;
  assign pay_c.mem_write = bus.ex_mem_write;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // Next state, capture and redirect decision; flush overrides everything
  always_comb begin
    state_next     = state;
    capture_c      = 1'b0;
    redirect_next  = 1'b0;
    mem_valid_next = mem_valid_q;
    unique case (state)
      ST_RUN: begin
        capture_c = bus.ex_valid & bus.ex_ready;
        if (capture_c && taken_c) begin
          redirect_next = 1'b1;
          state_next    = ST_SHADOW;
        end
      end
      ST_SHADOW: state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
    if (capture_c)          mem_valid_next = 1'b1;
    else if (bus.mem_ready) mem_valid_next = 1'b0;
    if (bus.flush) begin
      state_next     = ST_RUN;
      capture_c      = 1'b0;
      redirect_next  = 1'b0;
      mem_valid_next = 1'b0;
    end
  end

  // Pipeline register and redirect pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q      <= 1'b0;
      pay_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mem_valid_q      <= mem_valid_next;
      redirect_valid_q <= redirect_next;
      if (capture_c)     pay_q         <= pay_c;
      if (redirect_next) redirect_pc_q <= target_c;
    end
  end

  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_result     = pay_q.result;
  assign bus.mem_rs2_data   = pay_q.rs2_data;
  assign bus.mem_rd         = pay_q.rd;
  assign bus.mem_funct3     = pay_q.funct3;
  assign bus.mem_reg_write  = pay_q.reg_write;
  assign bus.mem_mem_read   = pay_q.mem_read;
  assign bus.mem_mem_write  = pay_q.mem_write;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

`ifdef EXMEM_BRANCH_STATS_EN
  // Branch statistics, free-running and wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (capture_c && bus.ex_is_branch) branch_count <= XLEN'(branch_count + XLEN'(1));
      if (redirect_next)                 taken_count  <= XLEN'(taken_count + XLEN'(1));
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind = {branch, jal, jalr}; flags = {z, n, c, o}
  task automatic beat(input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [2:0] f3, input logic [2:0] kind, input logic [3:0] flags,
                      input logic [4:0] rd);
    bus.ex_valid     = 1'b1;
    bus.alu_result   = alu;
    bus.ex_pc        = pc;
    bus.ex_imm       = imm;
    bus.ex_funct3    = f3;
    bus.ex_is_branch = kind[2];
    bus.ex_is_jal    = kind[1];
    bus.ex_is_jalr   = kind[0];
    bus.z_flag       = flags[3];
    bus.n_flag       = flags[2];
    bus.c_flag       = flags[1];
    bus.o_flag       = flags[0];
    bus.ex_rd        = rd;
    bus.ex_rs2_data  = 32'h0;
    bus.ex_reg_write = 1'b1;
    bus.ex_mem_read  = 1'b0;
    bus.ex_mem_write = 1'b0;
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0;
    tick();
  endtask

  initial begin
    beat(32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 4'b0000, 5'd0);
    bus.ex_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b1;
    #3;
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_redirect", 32'(bus.redirect_valid), 32'd0);
    check("rst_mem_result", bus.mem_result, 32'h0);
    check("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(bus.mem_valid), 32'd0);

    // BEQ taken, then shadow drops the next beat
    beat(32'h0, 32'h100, 32'h20, 3'b000, 3'b100, 4'b1000, 5'd0);
    tick();
    check("beq_redirect", 32'(bus.redirect_valid), 32'd1);
    check("beq_target", bus.redirect_pc, 32'h120);
    check("beq_mem_valid", 32'(bus.mem_valid), 32'd1);
    beat(32'h55, 32'h104, 32'h0, 3'b000, 3'b000, 4'b0000, 5'd3);
    #1 check("shadow_ex_ready", 32'(bus.ex_ready), 32'd1);
    tick();
    check("shadow_drop", 32'(bus.mem_valid), 32'd0);
    check("redirect_one_cycle", 32'(bus.redirect_valid), 32'd0);
    tick();
    check("after_shadow_valid", 32'(bus.mem_valid), 32'd1);
    check("after_shadow_result", bus.mem_result, 32'h55);
    check("after_shadow_rd", 32'(bus.mem_rd), 32'd3);

    // BLTU with no borrow: not taken
    beat(32'hFFFF_FFF4, 32'h108, 32'h40, 3'b110, 3'b100, 4'b0110, 5'd0);
    tick();
    check("bltu_redirect", 32'(bus.redirect_valid), 32'd0);
    check("bltu_mem_valid", 32'(bus.mem_valid), 32'd1);
    check("bltu_result", bus.mem_result, 32'hFFFF_FFF4);

    // JALR clears bit 0, links pc+4
    beat(32'h203, 32'h40, 32'h0, 3'b000, 3'b001, 4'b0000, 5'd1);
    tick();
    check("jalr_redirect", 32'(bus.redirect_valid), 32'd1);
    check("jalr_target", bus.redirect_pc, 32'h202);
    check("jalr_link", bus.mem_result, 32'h44);
    idle();
    check("jalr_shadow_clear", 32'(bus.mem_valid), 32'd0);

    // BNE with Z=1: not taken
    beat(32'h0, 32'h10, 32'h8, 3'b001, 3'b100, 4'b1000, 5'd0);
    tick();
    check("bne_nt", 32'(bus.redirect_valid), 32'd0);
    // reserved funct3 010: not taken even with Z=1
    beat(32'h0, 32'h10, 32'h8, 3'b010, 3'b100, 4'b1000, 5'd0);
    tick();
    check("f3_010_nt", 32'(bus.redirect_valid), 32'd0);
    // BGEU with C=0: not taken
    beat(32'h0, 32'h10, 32'h8, 3'b111, 3'b100, 4'b0000, 5'd0);
    tick();
    check("bgeu_nt", 32'(bus.redirect_valid), 32'd0);

    // BLT N^O=1 with negative offset
    beat(32'h0, 32'h200, 32'hFFFF_FFF0, 3'b100, 3'b100, 4'b0100, 5'd0);
    tick();
    check("blt_redirect", 32'(bus.redirect_valid), 32'd1);
    check("blt_target", bus.redirect_pc, 32'h1F0);
    idle();
    // BGE N=O=1: taken
    beat(32'h0, 32'h300, 32'h10, 3'b101, 3'b100, 4'b0101, 5'd0);
    tick();
    check("bge_redirect", 32'(bus.redirect_valid), 32'd1);
    check("bge_target", bus.redirect_pc, 32'h310);
    idle();
    // JAL wraps both target and link
    beat(32'h0, 32'hFFFF_FFFC, 32'h8, 3'b000, 3'b010, 4'b0000, 5'd1);
    tick();
    check("jal_redirect", 32'(bus.redirect_valid), 32'd1);
    check("jal_target", bus.redirect_pc, 32'h4);
    check("jal_link", bus.mem_result, 32'h0);
    idle();

    // Backpressure: hold for 3 cycles, then capture pending beat
    beat(32'h11, 32'h500, 32'h0, 3'b010, 3'b000, 4'b0000, 5'd5);
    bus.ex_rs2_data  = 32'hAB;
    bus.ex_mem_write = 1'b1;
    tick();
    check("stall_first_valid", 32'(bus.mem_valid), 32'd1);
    bus.mem_ready = 1'b0;
    beat(32'h22, 32'h504, 32'h0, 3'b000, 3'b000, 4'b0000, 5'd6);
    bus.ex_rs2_data = 32'hCD;
    #1 check("stall_ex_ready", 32'(bus.ex_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(bus.mem_valid), 32'd1);
      check("stall_result", bus.mem_result, 32'h11);
      check("stall_rd", 32'(bus.mem_rd), 32'd5);
      check("stall_rs2", bus.mem_rs2_data, 32'hAB);
      check("stall_funct3", 32'(bus.mem_funct3), 32'd2);
      check("stall_mem_write", 32'(bus.mem_mem_write), 32'd1);
      check("stall_ready_low", 32'(bus.ex_ready), 32'd0);
    end
    bus.mem_ready = 1'b1;
    #1 check("unstall_ex_ready", 32'(bus.ex_ready), 32'd1);
    tick();
    check("unstall_result", bus.mem_result, 32'h22);
    check("unstall_rd", 32'(bus.mem_rd), 32'd6);
    check("unstall_mem_write", 32'(bus.mem_mem_write), 32'd0);
    idle();
    check("drain_valid", 32'(bus.mem_valid), 32'd0);

    // Flush beats a taken-branch capture
    beat(32'h33, 32'h600, 32'h0, 3'b000, 3'b000, 4'b0000, 5'd2);
    tick();
    beat(32'h0, 32'h100, 32'h20, 3'b000, 3'b100, 4'b1000, 5'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("flush_redirect", 32'(bus.redirect_valid), 32'd0);
    beat(32'h77, 32'h604, 32'h0, 3'b000, 3'b000, 4'b0000, 5'd4);
    #1 check("flush_run_ready", 32'(bus.ex_ready), 32'd1);
    tick();
    check("flush_run_capture", 32'(bus.mem_valid), 32'd1);
    check("flush_run_result", bus.mem_result, 32'h77);

    // Async reset in the shadow cycle
    beat(32'h0, 32'h700, 32'h100, 3'b000, 3'b010, 4'b0000, 5'd1);
    tick();
    check("pre_rst_redirect", 32'(bus.redirect_valid), 32'd1);
    bus.ex_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("arst_redirect", 32'(bus.redirect_valid), 32'd0);
    check("arst_redirect_pc", bus.redirect_pc, 32'h0);
    check("arst_mem_result", bus.mem_result, 32'h0);
    check("arst_mem_rd", 32'(bus.mem_rd), 32'd0);
    #2 rst_n = 1'b1;
    beat(32'h99, 32'h800, 32'h0, 3'b000, 3'b000, 4'b0000, 5'd7);
    tick();
    check("arst_run_capture", 32'(bus.mem_valid), 32'd1);
    check("arst_run_result", bus.mem_result, 32'h99);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
